// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider, N = 2..2^W-1,
// with a 50% duty cycle for both even and odd divisors.
//
// A posedge-domain counter/FSM generates clk_p. For odd N, a negedge register
// (clk_n) stretches the high phase by half a CLK cycle. Divisor reloads and
// stop/start decisions happen only at period boundaries, so CLK_OUT never glitches.
//
// Optional feature: define CLK_DIV_TICK_EN to add the TICK output. TICK is a
// registered one-cycle pulse during the first CLK cycle of every period.
module clk_div_prog #(
    parameter int W           = 4,
    parameter int DIV_DEFAULT = 7
) (
    input  logic         CLK,
    input  logic         CLRn,
    input  logic         EN,
    input  logic [W-1:0] DIV,
    input  logic         DIV_LD,
    output logic         CLK_OUT,
    output logic         ACTIVE
`ifdef CLK_DIV_TICK_EN
    ,
    output logic         TICK
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] DIV_INIT = W'(DIV_DEFAULT);
    localparam logic [W-1:0] DIV_MIN  = W'(2);

    state_t         state_reg;
    logic [W-1:0]   cnt_reg;
    logic [W-1:0]   n_cur_reg;
    logic [W-1:0]   n_pend_reg;
    logic           clk_p_reg;
    logic           clk_n_reg;

    logic [W-1:0]   half;
    logic [W:0]     cnt_inc;
    logic           at_boundary;
    logic [W-1:0]   div_clamped;

    // Derived values: half-period, next count (one bit wider so the compare is exact),
    // boundary detect, and the clamped divisor for the pending register.
    always_comb begin
        half        = n_cur_reg >> 1;
        cnt_inc     = {1'b0, cnt_reg} + (W+1)'(1);
        at_boundary = (cnt_reg == (n_cur_reg - W'(1)));
        div_clamped = (DIV < DIV_MIN) ? DIV_MIN : DIV;
    end

    // Pending divisor: captured on DIV_LD; a later load overwrites an unapplied value.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            n_pend_reg <= DIV_INIT;
        end else if (DIV_LD) begin
            n_pend_reg <= div_clamped;
        end
    end

    // Posedge FSM: counts through the period, drives clk_p, and applies
    // the pending divisor or stops only at the boundary.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            n_cur_reg <= DIV_INIT;
            clk_p_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (EN) begin
                        state_reg <= RUN;
                        n_cur_reg <= n_pend_reg;
                        clk_p_reg <= 1'b1;
                    end else begin
                        clk_p_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (!at_boundary) begin
                        cnt_reg   <= cnt_inc[W-1:0];
                        clk_p_reg <= (cnt_inc < {1'b0, half});
                    end else if (EN) begin
                        cnt_reg   <= '0;
                        n_cur_reg <= n_pend_reg;
                        clk_p_reg <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        clk_p_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    clk_p_reg <= 1'b0;
                end
            endcase
        end
    end

    // Negedge phase register: extends the high phase by half a cycle for odd N only.
    always_ff @(negedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            clk_n_reg <= 1'b0;
        end else begin
            clk_n_reg <= clk_p_reg & n_cur_reg[0];
        end
    end

`ifdef CLK_DIV_TICK_EN
    logic tick_reg;

    // Tick: high during the first cycle of each period, i.e. whenever the FSM
    // is about to enter (or re-enter) cnt==0 in RUN.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            tick_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE:    tick_reg <= EN;
                RUN:     tick_reg <= at_boundary & EN;
                default: tick_reg <= 1'b0;
            endcase
        end
    end

    assign TICK = tick_reg;
`endif

    assign CLK_OUT = clk_p_reg | clk_n_reg;
    assign ACTIVE  = (state_reg == RUN);

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: self-checking bench for clk_div_prog.
// The reference model tracks the output in half-cycle units: a period of
// divisor N lasts 2N half-cycles, and CLK_OUT is high for the first N of them.
module tb_clk_div_prog;

    logic       CLK;
    logic       CLRn;
    logic       EN;
    logic [3:0] DIV;
    logic       DIV_LD;
    logic       CLK_OUT;
    logic       ACTIVE;
`ifdef CLK_DIV_TICK_EN
    logic       TICK;
`endif

    clk_div_prog #(.W(4), .DIV_DEFAULT(7)) dut (
        .CLK     (CLK),
        .CLRn    (CLRn),
        .EN      (EN),
        .DIV     (DIV),
        .DIV_LD  (DIV_LD),
        .CLK_OUT (CLK_OUT),
        .ACTIVE  (ACTIVE)
`ifdef CLK_DIV_TICK_EN
        ,
        .TICK    (TICK)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (half-cycle abstraction)
    bit m_run;
    int m_n;
    int m_pend;
    int m_pos;

    // Last observed samples
    logic last_hi;
    logic last_lo;
    logic last_active;

    typedef struct {
        logic [3:0] div;
        int         exp_high;
        int         exp_period;
        string      name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input logic [3:0] d);
        return (int'(d) < 2) ? 2 : int'(d);
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_n    = 7;
        m_pend = 7;
        m_pos  = 0;
    endtask

    // One CLK cycle: drive inputs, model the posedge, check, model the negedge, check.
    task automatic step(input logic en, input logic ld, input logic [3:0] div);
        int old_pend;
        EN     = en;
        DIV_LD = ld;
        DIV    = div;
        @(posedge CLK);
        old_pend = m_pend;
        if (ld) m_pend = clamp(div);
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_n   = old_pend;
                m_pos = 0;
            end
        end else if (m_pos + 1 == 2 * m_n) begin
            m_pos = 0;
            if (en) m_n = old_pend;
            else    m_run = 1'b0;
        end else begin
            m_pos = m_pos + 1;
        end
        #1;
        last_hi     = CLK_OUT;
        last_active = ACTIVE;
        check("model_active", 32'(ACTIVE), 32'(m_run));
        check("model_clk_out_pe", 32'(CLK_OUT), 32'(m_run && (m_pos < m_n)));
`ifdef CLK_DIV_TICK_EN
        check("model_tick", 32'(TICK), 32'(m_run && (m_pos == 0)));
`endif
        @(negedge CLK);
        if (m_run) m_pos = m_pos + 1;
        #1;
        last_lo = CLK_OUT;
        check("model_clk_out_ne", 32'(CLK_OUT), 32'(m_run && (m_pos < m_n)));
    endtask

    // Run with EN=1 and measure high time and period of CLK_OUT in half-cycles.
    task automatic measure(input string name, input int exp_high, input int exp_period);
        logic s[0:79];
        int   i_rise;
        int   i_fall;
        int   i_next;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 1'b0, 4'd0);
            s[2*c]   = last_hi;
            s[2*c+1] = last_lo;
        end
        i_rise = -1;
        i_fall = -1;
        i_next = -1;
        for (int i = 1; i < 80; i++) begin
            if (i_rise < 0) begin
                if (s[i] && !s[i-1]) i_rise = i;
            end else if (i_fall < 0) begin
                if (!s[i]) i_fall = i;
            end else if (i_next < 0) begin
                if (s[i]) i_next = i;
            end
        end
        if (i_next < 0) begin
            check({name, "_edges_found"}, 32'd0, 32'd1);
        end else begin
            check({name, "_rise_on_posedge"}, 32'(i_rise % 2), 32'd0);
            check({name, "_high_halfcycles"}, 32'(i_fall - i_rise), 32'(exp_high));
            check({name, "_period_halfcycles"}, 32'(i_next - i_rise), 32'(exp_period));
            $display("[TB] %s high=%0d period=%0d (half-cycles)", name, i_fall - i_rise, i_next - i_rise);
        end
    endtask

    // Step with EN=1 until the model sits at the given half-cycle of an N=n period.
    task automatic wait_pos(input int n, input int pos);
        bit found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            step(1'b1, 1'b0, 4'd0);
            if (m_run && m_n == n && m_pos == pos + 1) found = 1'b1;
        end
        check("wait_pos_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        vecs[0] = '{div: 4'd0,  exp_high: 2,  exp_period: 4,  name: "div0_clamp"};
        vecs[1] = '{div: 4'd1,  exp_high: 2,  exp_period: 4,  name: "div1_clamp"};
        vecs[2] = '{div: 4'd2,  exp_high: 2,  exp_period: 4,  name: "div2"};
        vecs[3] = '{div: 4'd3,  exp_high: 3,  exp_period: 6,  name: "div3"};
        vecs[4] = '{div: 4'd4,  exp_high: 4,  exp_period: 8,  name: "div4"};
        vecs[5] = '{div: 4'd5,  exp_high: 5,  exp_period: 10, name: "div5"};
        vecs[6] = '{div: 4'd6,  exp_high: 6,  exp_period: 12, name: "div6"};
        vecs[7] = '{div: 4'd15, exp_high: 15, exp_period: 30, name: "div15"};

        CLRn   = 1'b0;
        EN     = 1'b0;
        DIV    = 4'd0;
        DIV_LD = 1'b0;
        model_reset();
        #1;
        check("reset_clk_out", 32'(CLK_OUT), 32'd0);
        check("reset_active", 32'(ACTIVE), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        CLRn = 1'b1;

        // T1: default N=7, first rise on the first posedge with EN=1
        step(1'b1, 1'b0, 4'd0);
        check("t1_first_rise", 32'(last_hi), 32'd1);
        check("t1_active", 32'(last_active), 32'd1);
        measure("t1_default7", 7, 14);

        // T2: DIV=4 loaded mid-period of N=7; current period completes first
        wait_pos(7, 4);
        step(1'b1, 1'b1, 4'd4);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4'd0);
            check("t2_old_period_low", 32'(last_hi), 32'd0);
        end
        step(1'b1, 1'b0, 4'd0);
        check("t2_boundary_rise", 32'(last_hi), 32'd1);
        measure("t2_div4", 4, 8);

        // Table: load each divisor, let it take effect, measure the waveform (T3 included)
        for (int v = 0; v < 8; v++) begin
            step(1'b1, 1'b1, vecs[v].div);
            for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 4'd0);
            measure(vecs[v].name, vecs[v].exp_high, vecs[v].exp_period);
        end

        // T4: N=5, EN dropped at cnt=1; period completes, then stop, then restart
        step(1'b1, 1'b1, 4'd5);
        wait_pos(5, 0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 4'd0);
            check("t4_active_until_boundary", 32'(last_active), 32'd1);
        end
        step(1'b0, 1'b0, 4'd0);
        check("t4_stop_active", 32'(last_active), 32'd0);
        check("t4_stop_clk_out", 32'(last_hi), 32'd0);
        step(1'b0, 1'b0, 4'd0);
        check("t4_idle_clk_out", 32'(last_hi), 32'd0);
        step(1'b1, 1'b0, 4'd0);
        check("t4_restart_active", 32'(last_active), 32'd1);
        check("t4_restart_rise", 32'(last_hi), 32'd1);

        // T5: async reset in the high phase of N=7 discards pending DIV=3
        step(1'b1, 1'b1, 4'd7);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 4'd0);
        wait_pos(7, 0);
        step(1'b1, 1'b1, 4'd3);
        check("t5_pre_high", 32'(last_lo), 32'd1);
        #2;
        CLRn = 1'b0;
        #1;
        check("t5_async_clk_out", 32'(CLK_OUT), 32'd0);
        check("t5_async_active", 32'(ACTIVE), 32'd0);
        model_reset();
        @(negedge CLK);
        #1;
        CLRn = 1'b1;
        measure("t5_default_restored", 7, 14);

        // Randomised run against the model
        for (int k = 0; k < 600; k++) begin
            step(($urandom % 8) != 0, ($urandom % 6) == 0, 4'($urandom % 16));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
